cl_capture_ctrl: RTL and testbench

//  Command decoder and capture sequencer for the Camera Link capture path.

---
 rtl/cl_pkg.sv | 33 +++
 rtl/cl_cmd_decode.sv | 68 ++++++
 rtl/cl_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cl_capture_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - shared Camera Link capture constants, opcodes and state encoding
//
// Purpose: common definitions for the Camera Link capture path. Provides frame and
// line counter widths, PC message opcodes, the capture sequencer state encoding and
// a saturating frame counter increment.
// Ports: none (package).
package cl_pkg;

  localparam int FRAME_NUM_SIZE = 20;
  localparam int LINE_NUM_SIZE  = 12;
  localparam int CMD_PAYLOAD_W  = 2 * LINE_NUM_SIZE;

  localparam logic [3:0] OP_START   = 4'd1;
  localparam logic [3:0] OP_STOP    = 4'd2;
  localparam logic [3:0] OP_SET_ROI = 4'd3;
  localparam logic [3:0] OP_CLEAR   = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_CAPTURING = 3'd2,
    ST_DRAINING  = 3'd3,
    ST_ERROR     = 3'd4
  } cl_state_e;

  // Frame counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [FRAME_NUM_SIZE-1:0] frame_sat_inc(
    input logic [FRAME_NUM_SIZE-1:0] v
  );
    return (&v) ? v : v + FRAME_NUM_SIZE'(1);
  endfunction

endpackage

// File: rtl/cl_cmd_decode.sv
// rtl/cl_cmd_decode.sv - PC message handshake and opcode decode
//
// Purpose: accepts one PC message per handshake and splits it into one-cycle
// command strobes plus payload. The strobes are valid in the same cycle the ack
// flop is being set, so the consumer registers the command effect on the very
// edge that raises pc_msg_ack.
// Ports:
//   bus_clk, reset_n   clock, asynchronous active-low reset
//   pc_msg_pending     message available
//   pc_msg[31:0]       [31:28] opcode, [27:0] payload
//   pc_msg_ack         one-cycle consume pulse
//   cmd_start/stop/roi/clear  decoded command strobes
//   cmd_bad            strobe for any unrecognised opcode
//   cmd_payload[23:0]  low payload bits used by the commands
module cl_cmd_decode
  import cl_pkg::*;
(
  input  logic                     bus_clk,
  input  logic                     reset_n,
  input  logic                     pc_msg_pending,
  input  logic [31:0]              pc_msg,
  output logic                     pc_msg_ack,
  output logic                     cmd_start,
  output logic                     cmd_stop,
  output logic                     cmd_roi,
  output logic                     cmd_clear,
  output logic                     cmd_bad,
  output logic [CMD_PAYLOAD_W-1:0] cmd_payload
);

  logic       ack_q, ack_d;
  logic       take;
  logic [3:0] unused_payload;

  always_comb begin
    // The ack flop blocks acceptance in the cycle after a consume, so the FIFO
    // has time to advance: at most one message every second cycle.
    take           = pc_msg_pending && !ack_q;
    ack_d          = take;
    cmd_payload    = pc_msg[CMD_PAYLOAD_W-1:0];
    unused_payload = pc_msg[27:24];
    cmd_start      = 1'b0;
    cmd_stop       = 1'b0;
    cmd_roi        = 1'b0;
    cmd_clear      = 1'b0;
    cmd_bad        = 1'b0;
    if (take) begin
      case (pc_msg[31:28])
        OP_START:   cmd_start = 1'b1;
        OP_STOP:    cmd_stop  = 1'b1;
        OP_SET_ROI: cmd_roi   = 1'b1;
        OP_CLEAR:   cmd_clear = 1'b1;
        default:    cmd_bad   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign pc_msg_ack = ack_q;

endmodule

// File: rtl/cl_capture_ctrl.sv
// rtl/cl_capture_ctrl.sv - Camera Link capture command decoder and frame sequencer
//
// Purpose: arms, runs and stops frame capture on whole-frame boundaries under PC
// command, drives capture enable and ROI line limits to the datapath, and reports
// a registered status word.
// Ports:
//   bus_clk, reset_n          clock, asynchronous active-low reset
//   pc_msg_pending/pc_msg     incoming PC message, pc_msg_ack consume pulse
//   frame_start, frame_end    one-cycle FVAL edge pulses
//   fpga_msg_overflow         upstream FIFO overflow level
//   capture_en                datapath may emit data for the current frame
//   roi_first, roi_last       inclusive line window
//   status[31:0]              {state, ovf_sticky, bad_cmd, 7'b0, frames_done}
module cl_capture_ctrl
  import cl_pkg::*;
(
  input  logic                     bus_clk,
  input  logic                     reset_n,
  input  logic                     pc_msg_pending,
  input  logic [31:0]              pc_msg,
  output logic                     pc_msg_ack,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     fpga_msg_overflow,
  output logic                     capture_en,
  output logic [LINE_NUM_SIZE-1:0] roi_first,
  output logic [LINE_NUM_SIZE-1:0] roi_last,
  output logic [31:0]              status
);

  logic                     cmd_start, cmd_stop, cmd_roi, cmd_clear, cmd_bad;
  logic [CMD_PAYLOAD_W-1:0] cmd_payload;

  cl_cmd_decode u_cmd_decode (
    .bus_clk        (bus_clk),
    .reset_n        (reset_n),
    .pc_msg_pending (pc_msg_pending),
    .pc_msg         (pc_msg),
    .pc_msg_ack     (pc_msg_ack),
    .cmd_start      (cmd_start),
    .cmd_stop       (cmd_stop),
    .cmd_roi        (cmd_roi),
    .cmd_clear      (cmd_clear),
    .cmd_bad        (cmd_bad),
    .cmd_payload    (cmd_payload)
  );

  cl_state_e                 state_q, state_d;
  logic                      cap_q, cap_d;
  logic                      ovf_q, ovf_d;
  logic                      bad_q, bad_d;
  logic [FRAME_NUM_SIZE-1:0] target_q, target_d;
  logic [FRAME_NUM_SIZE-1:0] done_q, done_d;
  logic [LINE_NUM_SIZE-1:0]  roi_first_q, roi_first_d;
  logic [LINE_NUM_SIZE-1:0]  roi_last_q, roi_last_d;
  logic [FRAME_NUM_SIZE-1:0] done_base, done_inc;
  logic [LINE_NUM_SIZE-1:0]  new_first, new_last;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    target_d    = target_q;
    done_d      = done_q;
    roi_first_d = roi_first_q;
    roi_last_d  = roi_last_q;
    new_first   = cmd_payload[2*LINE_NUM_SIZE-1:LINE_NUM_SIZE];
    new_last    = cmd_payload[LINE_NUM_SIZE-1:0];
    // A CLEAR landing on a frame_end counts that frame from zero.
    done_base   = cmd_clear ? '0 : done_q;
    done_inc    = frame_sat_inc(done_base);

    if (cmd_clear) begin
      ovf_d  = 1'b0;
      bad_d  = 1'b0;
      done_d = '0;
    end
    if (cmd_bad) bad_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d  = ST_ARMED;
          done_d   = '0;
          target_d = cmd_payload[FRAME_NUM_SIZE-1:0];
        end
        if (cmd_roi) begin
          roi_first_d = new_first;
          roi_last_d  = new_last;
          if (new_first > new_last) bad_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (cmd_start || cmd_roi) bad_d = 1'b1;
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (frame_start) begin
          state_d = ST_CAPTURING;
          cap_d   = 1'b1;
        end
      end
      ST_CAPTURING: begin
        if (cmd_start || cmd_roi) bad_d = 1'b1;
        if (frame_end) begin
          done_d = done_inc;
          // A STOP coinciding with frame_end needs no drain: the frame is whole.
          // Any frame_start in the same cycle keeps capture_en high unless the
          // run ends here, in which case that new frame is dropped.
          if ((target_q != '0 && done_inc == target_q) || cmd_stop) begin
            state_d = ST_IDLE;
            cap_d   = 1'b0;
          end
        end else if (cmd_stop) begin
          state_d = ST_DRAINING;
        end
      end
      ST_DRAINING: begin
        if (cmd_start || cmd_roi) bad_d = 1'b1;
        if (frame_end) begin
          done_d  = done_inc;
          state_d = ST_IDLE;
          cap_d   = 1'b0;
        end
      end
      ST_ERROR: begin
        cap_d = 1'b0;
        if (cmd_start || cmd_stop || cmd_roi) bad_d = 1'b1;
        if (cmd_clear) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cap_d   = 1'b0;
      end
    endcase

    // Overflow wins over every command and frame event seen in the same cycle.
    if (fpga_msg_overflow) begin
      state_d     = ST_ERROR;
      cap_d       = 1'b0;
      ovf_d       = 1'b1;
      bad_d       = bad_q;
      target_d    = target_q;
      done_d      = done_q;
      roi_first_d = roi_first_q;
      roi_last_d  = roi_last_q;
    end
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cap_q       <= 1'b0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      target_q    <= '0;
      done_q      <= '0;
      roi_first_q <= '0;
      roi_last_q  <= '1;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      target_q    <= target_d;
      done_q      <= done_d;
      roi_first_q <= roi_first_d;
      roi_last_q  <= roi_last_d;
    end
  end

  assign capture_en = cap_q;
  assign roi_first  = roi_first_q;
  assign roi_last   = roi_last_q;
  assign status     = {state_q, ovf_q, bad_q, 7'b0, done_q};

endmodule

// File: tb/tb_cl_capture_ctrl.sv
// tb/tb_cl_capture_ctrl.sv - self-checking bench for cl_capture_ctrl
module tb_cl_capture_ctrl;

  logic        bus_clk = 1'b0;
  logic        reset_n;
  logic        pc_msg_pending;
  logic [31:0] pc_msg;
  logic        pc_msg_ack;
  logic        frame_start;
  logic        frame_end;
  logic        fpga_msg_overflow;
  logic        capture_en;
  logic [11:0] roi_first;
  logic [11:0] roi_last;
  logic [31:0] status;

  always #5 bus_clk = ~bus_clk;

  cl_capture_ctrl dut (
    .bus_clk           (bus_clk),
    .reset_n           (reset_n),
    .pc_msg_pending    (pc_msg_pending),
    .pc_msg            (pc_msg),
    .pc_msg_ack        (pc_msg_ack),
    .frame_start       (frame_start),
    .frame_end         (frame_end),
    .fpga_msg_overflow (fpga_msg_overflow),
    .capture_en        (capture_en),
    .roi_first         (roi_first),
    .roi_last          (roi_last),
    .status            (status)
  );

  localparam int S_IDLE = 0, S_ARM = 1, S_CAP = 2, S_DRN = 3, S_ERR = 4;
  localparam int DONE_MAX = (1 << 20) - 1;
  localparam logic [31:0] MSG_STOP  = 32'h2000_0000;
  localparam logic [31:0] MSG_CLEAR = 32'h4000_0000;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];

  int m_state, m_done, m_target, m_rf, m_rl;
  bit m_ack, m_cap, m_ovf, m_bad;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_done = 0; m_target = 0; m_rf = 0; m_rl = 4095;
    m_ack = 0; m_cap = 0; m_ovf = 0; m_bad = 0;
  endtask

  // Behavioural rules: commands act on the state seen at the edge, then frame
  // events (end before start) act on whatever state the command left, but only
  // if the block was already in a frame-tracking state.
  task automatic model_step();
    bit take;
    int op, s0;
    take  = pc_msg_pending && !m_ack;
    m_ack = take;
    if (take) void'(mq.pop_front());
    if (fpga_msg_overflow) begin
      m_ovf = 1; m_state = S_ERR; m_cap = 0;
      return;
    end
    s0 = m_state;
    if (take) begin
      op = int'(pc_msg[31:28]);
      case (op)
        1: if (s0 == S_IDLE) begin
             m_state = S_ARM; m_done = 0; m_target = int'(pc_msg[19:0]);
           end else m_bad = 1;
        2: if (s0 == S_ARM) m_state = S_IDLE;
           else if (s0 == S_CAP) m_state = S_DRN;
           else if (s0 == S_ERR) m_bad = 1;
        3: if (s0 == S_IDLE) begin
             m_rf = int'(pc_msg[23:12]); m_rl = int'(pc_msg[11:0]);
             if (m_rf > m_rl) m_bad = 1;
           end else m_bad = 1;
        4: begin
             m_ovf = 0; m_bad = 0; m_done = 0;
             if (s0 == S_ERR) m_state = S_IDLE;
           end
        default: m_bad = 1;
      endcase
    end
    if (s0 == S_ARM || s0 == S_CAP || s0 == S_DRN) begin
      if (frame_end && (m_state == S_CAP || m_state == S_DRN)) begin
        if (m_done < DONE_MAX) m_done++;
        if (m_state == S_DRN || (m_target != 0 && m_done == m_target)) begin
          m_state = S_IDLE; m_cap = 0;
        end
      end
      if (frame_start && m_state == S_ARM) begin
        m_state = S_CAP; m_cap = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_status;
    exp_status = (32'(m_state) << 29) | (32'(m_ovf) << 28) | (32'(m_bad) << 27) | 32'(m_done);
    expect_eq("ack", 32'(pc_msg_ack), 32'(m_ack));
    expect_eq("capture_en", 32'(capture_en), 32'(m_cap));
    expect_eq("roi_first", 32'(roi_first), 32'(m_rf));
    expect_eq("roi_last", 32'(roi_last), 32'(m_rl));
    expect_eq("status", status, exp_status);
  endtask

  task automatic cycle(input bit f_s, input bit f_e, input bit ov);
    frame_start       = f_s;
    frame_end         = f_e;
    fpga_msg_overflow = ov;
    pc_msg_pending    = (mq.size() != 0);
    pc_msg            = pc_msg_pending ? mq[0] : 32'h0;
    @(posedge bus_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic send(input logic [31:0] m);
    mq.push_back(m);
    for (int i = 0; i < 8 && mq.size() != 0; i++) cycle(0, 0, 0);
    if (mq.size() != 0) begin
      expect_eq("send_timeout", 32'(mq.size()), 32'd0);
      mq.delete();
    end
    cycle(0, 0, 0);
  endtask

  function automatic logic [31:0] mk_start(input int n);
    return {4'd1, 8'd0, 20'(n)};
  endfunction

  function automatic logic [31:0] mk_roi(input int f, input int l);
    return {4'd3, 4'd0, 12'(f), 12'(l)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; pc_msg_pending = 1'b0; pc_msg = '0;
    frame_start = 1'b0; frame_end = 1'b0; fpga_msg_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge bus_clk);
    #1;
    expect_eq("rst_status", status, 32'h0);
    expect_eq("rst_roi_last", 32'(roi_last), 32'hFFF);
    expect_eq("rst_cap", 32'(capture_en), 32'd0);
    reset_n = 1'b1;

    // ROI programming in IDLE, rejected outside IDLE, reversed window flagged
    send(mk_roi(10, 500));
    expect_eq("t5_first", 32'(roi_first), 32'd10);
    expect_eq("t5_last", 32'(roi_last), 32'd500);
    send(mk_start(0));
    send(mk_roi(1, 2));
    expect_eq("t5_armed_first", 32'(roi_first), 32'd10);
    expect_eq("t5_armed_bad", 32'(status[27]), 32'd1);
    send(MSG_STOP);
    send(MSG_CLEAR);
    send(mk_roi(600, 20));
    expect_eq("t5_rev_first", 32'(roi_first), 32'd600);
    expect_eq("t5_rev_bad", 32'(status[27]), 32'd1);
    send(MSG_CLEAR);

    // counted capture of 3 frames; the 4th is ignored
    send(mk_start(3));
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0);
      if (k == 0) expect_eq("t2_cap_on", 32'(capture_en), 32'd1);
      if (k == 3) expect_eq("t2_f4_cap", 32'(capture_en), 32'd0);
      idle(3);
      cycle(0, 1, 0);
      idle(2);
    end
    expect_eq("t2_done", 32'(status[19:0]), 32'd3);
    expect_eq("t2_state", 32'(status[31:29]), 32'd0);

    // STOP mid-frame drains that frame
    send(mk_start(0));
    cycle(1, 0, 0);
    idle(2);
    send(MSG_STOP);
    expect_eq("t3_draining", 32'(status[31:29]), 32'd3);
    expect_eq("t3_cap_hold", 32'(capture_en), 32'd1);
    idle(2);
    cycle(0, 1, 0);
    expect_eq("t3_cap_off", 32'(capture_en), 32'd0);
    expect_eq("t3_done", 32'(status[19:0]), 32'd1);

    // back-to-back frame boundary keeps capture_en high
    send(mk_start(2));
    cycle(1, 0, 0);
    idle(3);
    cycle(1, 1, 0);
    expect_eq("t6_no_gap", 32'(capture_en), 32'd1);
    expect_eq("t6_done1", 32'(status[19:0]), 32'd1);
    idle(3);
    cycle(0, 1, 0);
    expect_eq("t6_done2", 32'(status[19:0]), 32'd2);
    expect_eq("t6_idle", 32'(status[31:29]), 32'd0);

    // overflow -> ERROR, commands rejected until CLEAR
    send(mk_start(0));
    cycle(1, 0, 0);
    idle(2);
    cycle(0, 0, 1);
    expect_eq("t4_err", 32'(status[31:29]), 32'd4);
    expect_eq("t4_ovf", 32'(status[28]), 32'd1);
    expect_eq("t4_cap", 32'(capture_en), 32'd0);
    send(mk_start(1));
    expect_eq("t4_bad", 32'(status[27]), 32'd1);
    send(MSG_CLEAR);
    expect_eq("t4_clear", status, 32'h0);

    // unknown opcode
    send(32'hF000_0000);
    expect_eq("t7_bad", 32'(status[27]), 32'd1);
    expect_eq("t7_state", 32'(status[31:29]), 32'd0);
    send(MSG_CLEAR);

    // two queued messages are consumed on alternate cycles
    mq.push_back(mk_roi(1, 2));
    mq.push_back(mk_roi(3, 4));
    cycle(0, 0, 0);
    expect_eq("b2b_ack1", 32'(pc_msg_ack), 32'd1);
    cycle(0, 0, 0);
    expect_eq("b2b_gap", 32'(pc_msg_ack), 32'd0);
    cycle(0, 0, 0);
    expect_eq("b2b_ack2", 32'(pc_msg_ack), 32'd1);
    idle(2);
    expect_eq("b2b_roi", 32'(roi_first), 32'd3);

    // asynchronous reset while capturing
    send(mk_start(0));
    cycle(1, 0, 0);
    idle(2);
    #2;
    reset_n = 1'b0;
    #1;
    expect_eq("t1_cap", 32'(capture_en), 32'd0);
    expect_eq("t1_status", status, 32'h0);
    expect_eq("t1_roi_last", 32'(roi_last), 32'hFFF);
    expect_eq("t1_roi_first", 32'(roi_first), 32'h0);
    frame_start = 1'b0; frame_end = 1'b0; fpga_msg_overflow = 1'b0;
    pc_msg_pending = 1'b0;
    mq.delete();
    model_reset();
    @(posedge bus_clk);
    #1;
    reset_n = 1'b1;

    // randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (mq.size() < 2) begin
        if (r < 6)       mq.push_back(mk_start(int'($urandom_range(0, 3))));
        else if (r < 10) mq.push_back(MSG_STOP);
        else if (r < 14) mq.push_back(mk_roi(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
        else if (r < 16) mq.push_back(MSG_CLEAR);
        else if (r < 17) mq.push_back({4'(($urandom_range(5, 16)) & 15), 28'($urandom)});
      end
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
